// File: rtl/des_pkg.sv
// Shared definitions for the expansion / key-mix datapath.
//   mode_e       : per-beat operating mode (expand or contract)
//   ERR_CNT_W    : width of the saturating duplicate-mismatch counter
//   expand_idx   : source bit of the half-block feeding expanded bit j
//   nibble_pos   : expanded bit holding half-block bit i in its nibble slot
// Bit positions are LSB-based integers. Groups are counted from the MSB.
package des_pkg;

    localparam int ERR_CNT_W = 16;

    typedef enum logic {
        MODE_EXPAND   = 1'b0,
        MODE_CONTRACT = 1'b1
    } mode_e;

    // Each 6-bit output group is {L, nibble, R}. L is the last bit of the
    // previous nibble. R is the first bit of the next nibble. Both wrap
    // around the half-block.
    function automatic int expand_idx(input int w, input int j);
        int ew;
        int g;
        int p;
        ew = 3 * w / 2;
        g  = (ew - 1 - j) / 6;
        p  = (ew - 1 - j) % 6;
        if (p == 0)
            return (w - 4 * g) % w;
        else if (p == 5)
            return (2 * w - 5 - 4 * g) % w;
        else
            return w - 1 - 4 * g - (p - 1);
    endfunction

    function automatic int nibble_pos(input int w, input int i);
        int g;
        int k;
        g = (w - 1 - i) / 4;
        k = (w - 1 - i) % 4;
        return 3 * w / 2 - 2 - 6 * g - k;
    endfunction

endpackage

// File: rtl/expand_contract_core.sv
// Combinational expansion / contraction with subkey XOR.
//   mode   : 0 = expand, 1 = contract
//   data   : expand uses [W-1:0]; contract uses all EW bits
//   key    : EW-bit round subkey
//   result : expand gives EW bits; contract gives [W-1:0] with upper bits 0
//   err    : contract only, set when any duplicated bit pair disagrees
module expand_contract_core
    import des_pkg::*;
#(
    parameter int W = 32,
    localparam int EW = 3 * W / 2
) (
    input  logic          mode,
    input  logic [EW-1:0] data,
    input  logic [EW-1:0] key,
    output logic [EW-1:0] result,
    output logic          err
);

    logic [EW-1:0] expd;
    logic [EW-1:0] x;
    logic [EW-1:0] diff;
    logic [W-1:0]  contr;

    assign x = data ^ key;

    // Every expanded bit is compared with the nibble-slot copy of the same
    // source bit. For bits that are themselves nibble slots, the copy is the
    // same bit, so the comparison gives 0.
    for (genvar j = 0; j < EW; j++) begin : g_bit
        localparam int SRC = expand_idx(W, j);
        localparam int DUP = nibble_pos(W, SRC);
        assign expd[j] = data[SRC];
        assign diff[j] = x[j] ^ x[DUP];
    end

    for (genvar i = 0; i < W; i++) begin : g_contr
        localparam int POS = nibble_pos(W, i);
        assign contr[i] = x[POS];
    end

    always_comb begin
        result = expd ^ key;
        err    = 1'b0;
        if (mode_e'(mode) == MODE_CONTRACT) begin
            result = {{(EW - W){1'b0}}, contr};
            err    = |diff;
        end
    end

endmodule

// File: rtl/expand_keymix_pipe.sv
// Pipelined expansion / key-mix stage with a valid/ready handshake.
//   clk, rst               : clock; synchronous active-high reset
//   in_valid/in_ready      : input handshake (in_ready depends on out_ready)
//   in_mode                : 0 = expand, 1 = contract, captured per beat
//   in_data, in_key        : EW-bit word and subkey, captured per beat
//   out_valid/out_ready    : output handshake
//   out_data, out_err      : result and duplicate-mismatch flag
//   err_count              : saturating count of erroneous words delivered
// PIPE=2 registers the inputs first and then the result. PIPE=1 registers
// only the result.
module expand_keymix_pipe
    import des_pkg::*;
#(
    parameter int W    = 32,
    parameter int PIPE = 2,
    localparam int EW  = 3 * W / 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 in_mode,
    input  logic [EW-1:0]        in_data,
    input  logic [EW-1:0]        in_key,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [EW-1:0]        out_data,
    output logic                 out_err,
    output logic [ERR_CNT_W-1:0] err_count
);

    logic          c_mode;
    logic [EW-1:0] c_data;
    logic [EW-1:0] c_key;
    logic [EW-1:0] c_res;
    logic          c_err;
    logic          feed_vld;
    logic          s2_ready;

    logic          vld_p2;
    logic          err_p2;
    logic [EW-1:0] res_p2;

    // A stage loads when it is empty or its word leaves this cycle.
    assign s2_ready = !vld_p2 || out_ready;

    if (PIPE == 2) begin : g_pipe2
        logic          vld_p1;
        logic          mode_p1;
        logic [EW-1:0] data_p1;
        logic [EW-1:0] key_p1;
        logic          s1_ready;

        assign s1_ready = !vld_p1 || s2_ready;
        assign in_ready = !rst && s1_ready;

        // ---- stage 1: capture mode, key and data ----
        always_ff @(posedge clk) begin
            if (rst)
                vld_p1 <= 1'b0;
            else if (s1_ready)
                vld_p1 <= in_valid;
        end

        always_ff @(posedge clk) begin
            if (s1_ready && in_valid) begin
                mode_p1 <= in_mode;
                data_p1 <= in_data;
                key_p1  <= in_key;
            end
        end

        assign feed_vld = vld_p1;
        assign c_mode   = mode_p1;
        assign c_data   = data_p1;
        assign c_key    = key_p1;
    end else begin : g_pipe1
        assign in_ready = !rst && s2_ready;
        assign feed_vld = in_valid;
        assign c_mode   = in_mode;
        assign c_data   = in_data;
        assign c_key    = in_key;
    end

    expand_contract_core #(.W(W)) u_core (
        .mode   (c_mode),
        .data   (c_data),
        .key    (c_key),
        .result (c_res),
        .err    (c_err)
    );

    // ---- stage 2: compute, register result and error ----
    // The result registers are reset too, so that out_data reads 0 after reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p2 <= 1'b0;
            res_p2 <= '0;
            err_p2 <= 1'b0;
        end else if (s2_ready) begin
            vld_p2 <= feed_vld;
            if (feed_vld) begin
                res_p2 <= c_res;
                err_p2 <= c_err;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst)
            err_count <= '0;
        else if (vld_p2 && out_ready && err_p2 && (err_count != '1))
            err_count <= err_count + ERR_CNT_W'(1);
    end

    assign out_valid = vld_p2;
    assign out_data  = res_p2;
    assign out_err   = err_p2;

endmodule

// File: tb/tb_expand_keymix_pipe.sv
module tb_expand_keymix_pipe;

    logic        clk;
    int          pass_cnt;
    int          total_cnt;

    // W=32, PIPE=2 instance
    logic        a_rst, a_in_valid, a_in_ready, a_in_mode, a_out_valid, a_out_ready, a_out_err;
    logic [47:0] a_in_data, a_in_key, a_out_data;
    logic [15:0] a_err_count;

    // W=8, PIPE=1 instance
    logic        b_rst, b_in_valid, b_in_ready, b_in_mode, b_out_valid, b_out_ready, b_out_err;
    logic [11:0] b_in_data, b_in_key, b_out_data;
    logic [15:0] b_err_count;

    expand_keymix_pipe #(.W(32), .PIPE(2)) dut_a (
        .clk(clk), .rst(a_rst), .in_valid(a_in_valid), .in_ready(a_in_ready),
        .in_mode(a_in_mode), .in_data(a_in_data), .in_key(a_in_key),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
        .out_err(a_out_err), .err_count(a_err_count)
    );

    expand_keymix_pipe #(.W(8), .PIPE(1)) dut_b (
        .clk(clk), .rst(b_rst), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .in_mode(b_in_mode), .in_data(b_in_data), .in_key(b_in_key),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
        .out_err(b_out_err), .err_count(b_err_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        string       name;
        logic        mode;
        logic [47:0] data;
        logic [47:0] key;
        logic [47:0] exp_data;
        logic        exp_err;
    } vec_t;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        total_cnt++;
        if (got === exp)
            pass_cnt++;
        else
            $display("FAIL %s: got %h, expected %h", name, got, exp);
    endtask

    // Reference: build each 6-bit group from its nibble and the neighbouring
    // bits of the adjacent nibbles, with wrap-around.
    function automatic logic [47:0] m_expand(input int w, input logic [31:0] r);
        logic [47:0] o;
        logic [3:0]  nib;
        logic [5:0]  grp;
        int          ew;
        ew = 3 * w / 2;
        o  = '0;
        for (int g = 0; g < w / 4; g++) begin
            nib = 4'((r >> (w - 4 - 4 * g)) & 32'hF);
            grp = {r[(w - 4 * g) % w], nib, r[(2 * w - 5 - 4 * g) % w]};
            o   = o | (48'(grp) << (ew - 6 - 6 * g));
        end
        return o;
    endfunction

    // Reference contract: take the middle four bits of each group. The word
    // is consistent exactly when re-expanding those bits reproduces it.
    task automatic m_contract(input int w, input logic [47:0] x, output logic [31:0] d, output logic e);
        int         ew;
        logic [3:0] nib;
        ew = 3 * w / 2;
        d  = '0;
        for (int g = 0; g < w / 4; g++) begin
            nib = 4'((x >> (ew - 5 - 6 * g)) & 48'hF);
            d   = d | (32'(nib) << (w - 4 - 4 * g));
        end
        e = (m_expand(w, d) != x);
    endtask

    // Single beat through one instance; checks acceptance, latency, data and error.
    task automatic beat(input string name, input bit on_b, input logic mode,
                        input logic [47:0] d, input logic [47:0] k,
                        input logic [47:0] ed, input logic ee);
        bit ok;
        int lat;
        if (on_b) begin
            b_in_mode = mode; b_in_data = d[11:0]; b_in_key = k[11:0];
            b_in_valid = 1'b1; b_out_ready = 1'b1;
        end else begin
            a_in_mode = mode; a_in_data = d; a_in_key = k;
            a_in_valid = 1'b1; a_out_ready = 1'b1;
        end
        ok = 1'b0;
        for (int n = 0; n < 20 && !ok; n++) begin
            @(negedge clk);
            ok = on_b ? b_in_ready : a_in_ready;
        end
        check({name, "_accept"}, 64'(ok), 64'd1);
        @(posedge clk); #1;
        a_in_valid = 1'b0;
        b_in_valid = 1'b0;
        if (!ok) return;
        ok  = 1'b0;
        lat = 0;
        while (!ok && lat < 20) begin
            @(negedge clk);
            lat++;
            ok = on_b ? b_out_valid : a_out_valid;
        end
        check({name, "_latency"}, 64'(lat), on_b ? 64'd1 : 64'd2);
        check({name, "_data"}, on_b ? 64'(b_out_data) : 64'(a_out_data), 64'(ed));
        check({name, "_err"}, on_b ? 64'(b_out_err) : 64'(a_out_err), 64'(ee));
        @(posedge clk); #1;
    endtask

    initial begin
        vec_t        vecs[8];
        logic [31:0] rr[500];
        logic [47:0] kk[500];
        logic [47:0] exp_q[$];
        logic [47:0] exp_w;
        logic [47:0] y;
        logic [31:0] cd;
        logic        ce;
        logic [47:0] snap;
        bit          have_snap;
        bit          acc_now;
        int          idx, got, acc, rcv, extra, pi, nval;

        pass_cnt = 0; total_cnt = 0;
        a_rst = 1'b1; b_rst = 1'b1;
        a_in_valid = 1'b0; b_in_valid = 1'b0;
        a_in_mode = 1'b0; b_in_mode = 1'b0;
        a_in_data = '0; a_in_key = '0; b_in_data = '0; b_in_key = '0;
        a_out_ready = 1'b1; b_out_ready = 1'b1;

        vecs[0] = '{"exp_lsb",    1'b0, 48'h0000_0000_0001, 48'h0,              48'h8000_0000_0002, 1'b0};
        vecs[1] = '{"exp_msb",    1'b0, 48'h0000_8000_0000, 48'h0,              48'h4000_0000_0001, 1'b0};
        vecs[2] = '{"exp_ones",   1'b0, 48'h0000_FFFF_FFFF, 48'h0,              48'hFFFF_FFFF_FFFF, 1'b0};
        vecs[3] = '{"exp_upper",  1'b0, 48'hABCD_0000_0001, 48'h0,              48'h8000_0000_0002, 1'b0};
        vecs[4] = '{"exp_key",    1'b0, 48'h0000_0000_0001, 48'hFFFF_FFFF_FFFF, 48'h7FFF_FFFF_FFFD, 1'b0};
        vecs[5] = '{"con_ok",     1'b1, 48'h8000_0000_0002, 48'h0,              48'h0000_0000_0001, 1'b0};
        vecs[6] = '{"con_key",    1'b1, 48'h7FFF_FFFF_FFFD, 48'hFFFF_FFFF_FFFF, 48'h0000_0000_0001, 1'b0};
        vecs[7] = '{"con_err",    1'b1, 48'h8000_0000_0000, 48'h0,              48'h0000_0000_0000, 1'b1};

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", 64'(a_in_ready), 64'd0);
        check("rst_out_valid", 64'(a_out_valid), 64'd0);
        check("rst_out_data", 64'(a_out_data), 64'd0);
        check("rst_out_err", 64'(a_out_err), 64'd0);
        check("rst_err_count", 64'(a_err_count), 64'd0);
        @(posedge clk); #1;
        a_rst = 1'b0; b_rst = 1'b0;
        @(negedge clk);
        check("post_rst_in_ready", 64'(a_in_ready), 64'd1);
        @(posedge clk); #1;

        // Known-answer table
        for (int i = 0; i < 8; i++)
            beat(vecs[i].name, 1'b0, vecs[i].mode, vecs[i].data, vecs[i].key,
                 vecs[i].exp_data, vecs[i].exp_err);
        check("err_count_one", 64'(a_err_count), 64'd1);

        // Randomized round trip, alternating mode, random handshake
        for (int i = 0; i < 500; i++) begin
            rr[i] = $urandom;
            kk[i] = 48'({$urandom, $urandom});
        end
        idx = 0; got = 0;
        fork
            begin
                while (idx < 1000) begin
                    pi = idx / 2;
                    y  = m_expand(32, rr[pi]) ^ kk[pi];
                    if (idx % 2 == 0) begin
                        a_in_mode = 1'b0;
                        a_in_data = {16'($urandom), rr[pi]};
                    end else begin
                        a_in_mode = 1'b1;
                        a_in_data = y;
                    end
                    a_in_key    = kk[pi];
                    a_in_valid  = ($urandom_range(3) != 0);
                    a_out_ready = ($urandom_range(3) != 0);
                    @(negedge clk);
                    if (a_in_valid && a_in_ready) begin
                        exp_q.push_back((idx % 2 == 0) ? y : {16'h0, rr[pi]});
                        idx++;
                    end
                    @(posedge clk); #1;
                end
                a_in_valid  = 1'b0;
                a_out_ready = 1'b1;
            end
            begin
                for (int c = 0; c < 20000 && got < 1000; c++) begin
                    @(negedge clk);
                    if (a_out_valid && a_out_ready) begin
                        if (exp_q.size() == 0) begin
                            check("rt_a_unexpected", 64'(exp_q.size()), 64'd1);
                        end else begin
                            exp_w = exp_q.pop_front();
                            check("rt_a_word", {15'h0, a_out_err, a_out_data}, {16'h0, exp_w});
                        end
                        got++;
                    end
                end
                check("rt_a_count", 64'(got), 64'd1000);
            end
        join
        @(posedge clk); #1;
        check("err_count_hold", 64'(a_err_count), 64'd1);

        // Backpressure: exactly PIPE words enter, output held steady
        a_out_ready = 1'b0; a_in_valid = 1'b1; a_in_mode = 1'b0; a_in_key = '0;
        acc = 0; have_snap = 1'b0; a_in_data = 48'(acc + 1);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            acc_now = a_in_valid && a_in_ready;
            if (a_out_valid) begin
                if (have_snap)
                    check("stall_stable", 64'(a_out_data), 64'(snap));
                snap = a_out_data;
                have_snap = 1'b1;
            end
            @(posedge clk); #1;
            if (acc_now) begin
                acc++;
                a_in_data = 48'(acc + 1);
            end
        end
        check("stall_accepted", 64'(acc), 64'd2);
        @(negedge clk);
        check("stall_in_ready", 64'(a_in_ready), 64'd0);
        check("stall_out_valid", 64'(a_out_valid), 64'd1);
        @(posedge clk); #1;
        a_out_ready = 1'b1; a_in_valid = 1'b0;
        @(negedge clk);
        check("release_in_ready", 64'(a_in_ready), 64'd1);
        rcv = 0; extra = 0;
        for (int c = 0; c < 8; c++) begin
            if (c > 0) @(negedge clk);
            if (a_out_valid) begin
                if (rcv < 2)
                    check("release_order", 64'(a_out_data), 64'(m_expand(32, 32'(rcv + 1))));
                else
                    extra++;
                rcv++;
            end
            @(posedge clk); #1;
        end
        check("release_count", 64'(rcv), 64'd2);

        // Reset with two erroneous words in flight
        a_out_ready = 1'b0; a_in_valid = 1'b1; a_in_mode = 1'b1;
        a_in_data = 48'h8000_0000_0000; a_in_key = '0;
        acc = 0;
        for (int c = 0; c < 10 && acc < 2; c++) begin
            @(negedge clk);
            acc_now = a_in_valid && a_in_ready;
            @(posedge clk); #1;
            if (acc_now) acc++;
        end
        check("mid_rst_filled", 64'(acc), 64'd2);
        a_in_valid = 1'b0;
        a_rst = 1'b1;
        @(posedge clk); #1;
        a_rst = 1'b0; a_out_ready = 1'b1;
        @(negedge clk);
        check("mid_rst_in_ready", 64'(a_in_ready), 64'd1);
        check("mid_rst_err_count", 64'(a_err_count), 64'd0);
        nval = 0;
        for (int c = 0; c < 6; c++) begin
            if (a_out_valid) nval++;
            @(negedge clk);
        end
        check("mid_rst_no_output", 64'(nval), 64'd0);
        check("mid_rst_err_count_after", 64'(a_err_count), 64'd0);
        @(posedge clk); #1;

        // W=8, PIPE=1
        beat("b_exp_01", 1'b1, 1'b0, 48'h001, 48'h0, 48'h802, 1'b0);
        beat("b_con_802", 1'b1, 1'b1, 48'h802, 48'h0, 48'h001, 1'b0);
        for (int i = 0; i < 100; i++) begin
            rr[i] = 32'($urandom_range(255));
            kk[i] = 48'($urandom_range(4095));
            y = m_expand(8, rr[i]) ^ kk[i];
            m_contract(8, y ^ kk[i], cd, ce);
            beat("b_rt_exp", 1'b1, 1'b0, {36'h0, 4'($urandom), rr[i][7:0]}, kk[i], y, 1'b0);
            beat("b_rt_con", 1'b1, 1'b1, y, kk[i], {16'h0, cd}, ce);
            check("b_rt_identity", 64'(cd), 64'(rr[i]));
        end

        // err_count saturation on W=8
        b_rst = 1'b1;
        @(posedge clk); #1;
        b_rst = 1'b0;
        b_in_valid = 1'b1; b_out_ready = 1'b1; b_in_mode = 1'b1;
        b_in_data = 12'h800; b_in_key = 12'h000;
        repeat (10) @(posedge clk);
        @(negedge clk);
        check("b_err_count_9", 64'(b_err_count), 64'd9);
        check("b_out_err", 64'(b_out_err), 64'd1);
        repeat (65535) @(posedge clk);
        #1;
        b_in_valid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("b_err_count_sat", 64'(b_err_count), 64'hFFFF);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
